// File: rtl/set_readback_if.sv
// CPU-side bus signals of the settings read responder: cycle qualifiers in, data/acknowledge out.
interface set_readback_if;
  logic        BACT;
  logic        SetCSRD;
  logic        SetCSWR;
  logic [15:0] D;
  logic        DOE;
  logic        Ack;

  modport master (
    output BACT, SetCSRD, SetCSWR,
    input  D, DOE, Ack
  );

  modport slave (
    input  BACT, SetCSRD, SetCSWR,
    output D, DOE, Ack
  );
endinterface

// File: rtl/set_readback.sv
// Read-side responder for the settings register: snapshots the settings, inserts wait states, acks.
// Optional dirty-since-last-read flag in D[15] is built only when SET_READBACK_DIRTY_EN is defined.
module set_readback #(
  parameter int         WAIT_CYCLES = 2,
  parameter logic [2:0] VERSION     = 3'd1
) (
  input  logic           CLK,
  input  logic           nPOR,
  set_readback_if.slave  bus,
  input  logic [3:0]     SlowTimeout,
  input  logic           SlowIACK,
  input  logic           SlowVIA,
  input  logic           SlowIWM,
  input  logic           SlowSCC,
  input  logic           SlowSCSI,
  input  logic           SlowSnd,
  input  logic           SlowClockGate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        rd_req_p1;
  logic        snap_en;
  logic        rel;
  logic        dirty;
  logic [15:0] d_p2;

  function automatic logic [15:0] pack_word(
    input logic       dty,
    input logic [3:0] tmo,
    input logic [6:0] flg
  );
    return {dty, VERSION, tmo, flg, 1'b0};
  endfunction

  // Request stage: registered bus-cycle qualifier
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      rd_req_p1 <= 1'b0;
    end else begin
      rd_req_p1 <= bus.BACT && bus.SetCSRD;
    end
  end

`ifdef SET_READBACK_DIRTY_EN
  logic wr_req_p1;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      wr_req_p1 <= 1'b0;
    end else begin
      wr_req_p1 <= bus.BACT && bus.SetCSWR;
    end
  end

  // A write seen on the same edge as the read release keeps the flag set
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      dirty <= 1'b0;
    end else if (wr_req_p1) begin
      dirty <= 1'b1;
    end else if (rel) begin
      dirty <= 1'b0;
    end
  end
`else
  logic unused_wr;

  assign dirty     = 1'b0;
  assign unused_wr = bus.SetCSWR ^ rel;
`endif

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Exits look at the registered request so its trailing cycle cannot restart a read
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    snap_en  = 1'b0;
    rel      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req_p1) begin
          snap_en  = 1'b1;
          cnt_nx   = WAIT_LD;
          state_nx = (WAIT_LD == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!rd_req_p1) begin
          state_nx = IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!rd_req_p1) begin
          state_nx = IDLE;
          rel      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Snapshot stage: D is frozen for the whole read
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      d_p2 <= 16'h0000;
    end else if (snap_en) begin
      d_p2 <= pack_word(dirty, SlowTimeout,
                        {SlowIACK, SlowVIA, SlowIWM, SlowSCC,
                         SlowSCSI, SlowSnd, SlowClockGate});
    end
  end

  assign bus.D   = d_p2;
  assign bus.DOE = (state == WAIT) || (state == ACK);
  assign bus.Ack = (state == ACK);

endmodule
